// File: rtl/alu_share_arbiter_if.sv
// rtl/alu_share_arbiter_if.sv - request, response and ALU signal bundle for alu_share_arbiter
// Ports (signals):
//   req_valid/req_ready  per-requester handshake, req_a/req_b/req_op packed operands
//   alu_a/alu_b/alu_op   registered operands towards the ALU, alu_result back from it
//   rsp_valid/rsp_ready  response handshake, rsp_id/rsp_result tagged response
// Modports: slave = arbiter side, master = requesters + ALU + response consumer side.
interface alu_share_arbiter_if #(
    parameter int ALU_WIDTH = 16,
    parameter int N_REQ     = 4,
    parameter int ID_W      = $clog2(N_REQ)
);
    logic [N_REQ-1:0]           req_valid;
    logic [N_REQ-1:0]           req_ready;
    logic [N_REQ*ALU_WIDTH-1:0] req_a;
    logic [N_REQ*ALU_WIDTH-1:0] req_b;
    logic [N_REQ*2-1:0]         req_op;
    logic [ALU_WIDTH-1:0]       alu_a;
    logic [ALU_WIDTH-1:0]       alu_b;
    logic [1:0]                 alu_op;
    logic [ALU_WIDTH-1:0]       alu_result;
    logic                       rsp_valid;
    logic                       rsp_ready;
    logic [ID_W-1:0]            rsp_id;
    logic [ALU_WIDTH-1:0]       rsp_result;

    modport slave (
        input  req_valid, req_a, req_b, req_op, alu_result, rsp_ready,
        output req_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_id, rsp_result
    );

    modport master (
        output req_valid, req_a, req_b, req_op, alu_result, rsp_ready,
        input  req_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_id, rsp_result
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin arbiter sharing one combinational ALU among N_REQ requesters
// Ports:
//   clk          clock, all state on rising edge
//   rst_n        synchronous active-low reset
//   bus          alu_share_arbiter_if.slave (requests, ALU operands/result, tagged response)
//   stat_grants  per-requester saturating grant counters, 16 bits each (ALU_ARB_STATS_EN only)
//   stat_stall   saturating count of RESP cycles with rsp_ready low (ALU_ARB_STATS_EN only)
// Optional feature macro: ALU_ARB_STATS_EN
module alu_share_arbiter #(
    parameter int ALU_WIDTH = 16,
    parameter int N_REQ     = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    alu_share_arbiter_if.slave     bus
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [N_REQ*16-1:0]    stat_grants,
    output logic [15:0]            stat_stall
`endif
);
    localparam int ID_W = $clog2(N_REQ);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [ID_W-1:0]        r_rr_ptr;
    logic [ID_W-1:0]        r_cur_id;
    logic [ALU_WIDTH-1:0]   r_alu_a;
    logic [ALU_WIDTH-1:0]   r_alu_b;
    logic [1:0]             r_alu_op;
    logic                   r_rsp_valid;
    logic [ID_W-1:0]        r_rsp_id;
    logic [ALU_WIDTH-1:0]   r_rsp_result;

    logic                   w_any;
    logic [ID_W-1:0]        w_grant;
    logic [N_REQ-1:0]       w_grant_oh;
    logic [ALU_WIDTH-1:0]   w_sel_a;
    logic [ALU_WIDTH-1:0]   w_sel_b;
    logic [1:0]             w_sel_op;
    logic [ID_W-1:0]        w_ptr_nxt;
    logic                   w_accept;
    int                     w_idx;

    // Scan requesters starting at rr_ptr with wrap; first valid one wins.
    always_comb begin
        w_any      = 1'b0;
        w_grant    = '0;
        w_grant_oh = '0;
        w_sel_a    = '0;
        w_sel_b    = '0;
        w_sel_op   = '0;
        w_idx      = 0;
        for (int k = 0; k < N_REQ; k++) begin
            w_idx = (int'(r_rr_ptr) + k) % N_REQ;
            if (!w_any && bus.req_valid[w_idx]) begin
                w_any              = 1'b1;
                w_grant            = ID_W'(w_idx);
                w_grant_oh[w_idx]  = 1'b1;
                w_sel_a            = bus.req_a[w_idx*ALU_WIDTH +: ALU_WIDTH];
                w_sel_b            = bus.req_b[w_idx*ALU_WIDTH +: ALU_WIDTH];
                w_sel_op           = bus.req_op[w_idx*2 +: 2];
            end
        end
    end

    assign w_ptr_nxt = (w_grant == ID_W'(N_REQ - 1)) ? '0 : w_grant + ID_W'(1);
    assign w_accept  = (r_state == S_IDLE) && w_any;

    // Grant is only offered while idle and out of reset, so a pending response blocks new work.
    assign bus.req_ready  = (rst_n && r_state == S_IDLE) ? w_grant_oh : '0;
    assign bus.alu_a      = r_alu_a;
    assign bus.alu_b      = r_alu_b;
    assign bus.alu_op     = r_alu_op;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_id     = r_rsp_id;
    assign bus.rsp_result = r_rsp_result;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_any) w_state_nxt = S_EXEC;
            S_EXEC:  w_state_nxt = S_RESP;
            S_RESP:  if (r_rsp_valid && bus.rsp_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rr_ptr     <= '0;
            r_cur_id     <= '0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_op     <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= '0;
            r_rsp_result <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_alu_a  <= w_sel_a;
                        r_alu_b  <= w_sel_b;
                        r_alu_op <= w_sel_op;
                        r_cur_id <= w_grant;
                        r_rr_ptr <= w_ptr_nxt;
                    end
                end
                S_EXEC: begin
                    // ALU operands have been stable for a full cycle; capture its result.
                    r_rsp_result <= bus.alu_result;
                    r_rsp_id     <= r_cur_id;
                    r_rsp_valid  <= 1'b1;
                end
                S_RESP: begin
                    if (bus.rsp_ready) r_rsp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef ALU_ARB_STATS_EN
    logic [15:0] r_stat_grants [N_REQ];
    logic [15:0] r_stat_stall;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N_REQ; i++) r_stat_grants[i] <= '0;
            r_stat_stall <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (w_accept && w_grant == ID_W'(i) && r_stat_grants[i] != 16'hFFFF) begin
                    r_stat_grants[i] <= r_stat_grants[i] + 16'd1;
                end
            end
            if (r_state == S_RESP && !bus.rsp_ready && r_stat_stall != 16'hFFFF) begin
                r_stat_stall <= r_stat_stall + 16'd1;
            end
        end
    end

    always_comb begin
        stat_grants = '0;
        for (int i = 0; i < N_REQ; i++) stat_grants[i*16 +: 16] = r_stat_grants[i];
    end
    assign stat_stall = r_stat_stall;
`else
    logic w_unused_accept;
    assign w_unused_accept = w_accept;
`endif
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - randomized scoreboard bench for alu_share_arbiter
module tb_alu_share_arbiter;
    localparam int W = 16;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_share_arbiter_if #(.ALU_WIDTH(W), .N_REQ(N)) bus ();

`ifdef ALU_ARB_STATS_EN
    logic [N*16-1:0] stat_grants;
    logic [15:0]     stat_stall;
    alu_share_arbiter #(.ALU_WIDTH(W), .N_REQ(N)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave),
        .stat_grants(stat_grants), .stat_stall(stat_stall)
    );
`else
    alu_share_arbiter #(.ALU_WIDTH(W), .N_REQ(N)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave)
    );
`endif

    function automatic logic [W-1:0] alu_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [1:0] op);
        case (op)
            2'b00:   return a + b;
            2'b01:   return a - b;
            2'b10:   return a & b;
            default: return a ^ b;
        endcase
    endfunction

    assign bus.alu_result = alu_f(bus.alu_a, bus.alu_b, bus.alu_op);

    typedef struct packed {
        logic [1:0]   id;
        logic [W-1:0] res;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [1:0]   op;
    } exp_t;

    exp_t sb[$];
    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    bit     m_busy = 0;
    int     m_age = 0;
    int     m_ptr = 0;
    bit     m_was_rst = 0;
    int     acc_cnt = 0;
    int     m_grants[N];
    int     m_stall = 0;
    logic [N-1:0] acc = '0;

    // Stimulus controls
    logic [N-1:0] en_mask = '0;
    int           rate = 100;
    bit           use_fix = 0;
    logic [W-1:0] fix_a = '0;
    logic [W-1:0] fix_b = '0;
    logic [1:0]   fix_op = '0;
    bit           rand_rsp = 0;
    bit           hold_rsp = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    // Model + monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin : model_blk
        int   g;
        bit   b0;
        exp_t e;
        if (!rst_n) begin
            chk("ready_in_reset", 64'(bus.req_ready), 64'd0);
            sb.delete();
            m_busy = 0;
            m_ptr = 0;
            m_was_rst = 1;
            m_stall = 0;
            for (int i = 0; i < N; i++) m_grants[i] = 0;
        end else begin
            if (m_was_rst) begin
                chk("rst_alu_a", 64'(bus.alu_a), 64'd0);
                chk("rst_alu_b", 64'(bus.alu_b), 64'd0);
                chk("rst_alu_op", 64'(bus.alu_op), 64'd0);
                chk("rst_rsp_id", 64'(bus.rsp_id), 64'd0);
                chk("rst_rsp_result", 64'(bus.rsp_result), 64'd0);
                m_was_rst = 0;
            end
            b0 = m_busy;
            if (b0) begin
                m_age++;
                chk("rsp_valid_timing", 64'(bus.rsp_valid), 64'(m_age >= 2));
                chk("ready_while_busy", 64'(bus.req_ready), 64'd0);
                if (sb.size() > 0) begin
                    e = sb[0];
                    chk("alu_a", 64'(bus.alu_a), 64'(e.a));
                    chk("alu_b", 64'(bus.alu_b), 64'(e.b));
                    chk("alu_op", 64'(bus.alu_op), 64'(e.op));
                    if (bus.rsp_valid) begin
                        chk("rsp_id", 64'(bus.rsp_id), 64'(e.id));
                        chk("rsp_result", 64'(bus.rsp_result), 64'(e.res));
                        if (!bus.rsp_ready) begin
                            m_stall++;
                        end else begin
                            void'(sb.pop_front());
                            m_busy = 0;
                        end
                    end
                end
            end else begin
                chk("rsp_valid_idle", 64'(bus.rsp_valid), 64'd0);
                g = rr_pick(bus.req_valid, m_ptr);
                chk("grant", 64'(bus.req_ready), (g < 0) ? 64'd0 : (64'd1 << g));
                if (g >= 0) begin
                    e.id  = 2'(g);
                    e.a   = bus.req_a[g*W +: W];
                    e.b   = bus.req_b[g*W +: W];
                    e.op  = bus.req_op[g*2 +: 2];
                    e.res = alu_f(e.a, e.b, e.op);
                    sb.push_back(e);
                    m_busy = 1;
                    m_age = 0;
                    m_ptr = (g + 1) % N;
                    acc[g] = 1'b1;
                    acc_cnt++;
                    m_grants[g]++;
                end
            end
        end
    end

    // Requester + response-consumer driver
    initial begin
        bus.req_valid = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.req_op = '0;
        bus.rsp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (acc[i]) begin
                    bus.req_valid[i] = 1'b0;
                    acc[i] = 1'b0;
                end
                if (!bus.req_valid[i] && en_mask[i] && int'($urandom_range(99)) < rate) begin
                    bus.req_valid[i] = 1'b1;
                    bus.req_a[i*W +: W] = use_fix ? fix_a : W'($urandom);
                    bus.req_b[i*W +: W] = use_fix ? fix_b : W'($urandom);
                    bus.req_op[i*2 +: 2] = use_fix ? fix_op : 2'($urandom);
                end
            end
            bus.rsp_ready = hold_rsp ? 1'b0 : (rand_rsp ? ($urandom_range(3) != 0) : 1'b1);
        end
    end

    task automatic timeout(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timeout waiting, got no event expected one", name);
    endtask

    task automatic wait_acc(input int n);
        int target;
        bit ok;
        target = acc_cnt + n;
        ok = 0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            if (acc_cnt >= target) begin
                ok = 1;
                break;
            end
        end
        if (!ok) timeout("wait_acc");
    endtask

    task automatic drain();
        bit ok;
        ok = 0;
        en_mask = '0;
        for (int c = 0; c < 500; c++) begin
            @(posedge clk);
            if (bus.req_valid == '0 && !m_busy) begin
                ok = 1;
                break;
            end
        end
        if (!ok) timeout("drain");
        repeat (2) @(posedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic wait_rsp_valid();
        bit ok;
        ok = 0;
        for (int c = 0; c < 50; c++) begin
            @(posedge clk);
            if (bus.rsp_valid) begin
                ok = 1;
                break;
            end
        end
        if (!ok) timeout("wait_rsp_valid");
    endtask

    initial begin
        for (int i = 0; i < N; i++) m_grants[i] = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single request with fixed operands
        use_fix = 1; fix_a = 16'h0011; fix_b = 16'h000F; fix_op = 2'b00;
        en_mask = 4'b0001;
        wait_acc(1);
        drain();

        // All four valid continuously from reset
        use_fix = 0; rate = 100; en_mask = 4'b1111;
        do_reset();
        wait_acc(8);
        drain();

        // Wrap: grant 3, then only 1 and 3 valid
        en_mask = 4'b1000;
        wait_acc(1);
        en_mask = 4'b1010;
        wait_acc(3);
        drain();

        // Backpressure for 5 cycles in RESP
        use_fix = 1; fix_a = 16'hFF00; fix_b = 16'h00FF; fix_op = 2'b10;
        hold_rsp = 1; en_mask = 4'b0001;
        wait_acc(1);
        en_mask = '0;
        wait_rsp_valid();
        repeat (5) @(posedge clk);
        hold_rsp = 0;
        drain();

        // Reset while in EXEC
        use_fix = 0; en_mask = 4'b1111;
        wait_acc(1);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        wait_acc(4);
        drain();

        // Random traffic with random backpressure
        rand_rsp = 1; rate = 40; en_mask = 4'b1111;
        wait_acc(60);
        drain();
        rand_rsp = 0;

`ifdef ALU_ARB_STATS_EN
        // Three grants to requester 2 and four stall cycles
        do_reset();
        rate = 100; en_mask = 4'b0100;
        wait_acc(3);
        en_mask = '0;
        hold_rsp = 1;
        wait_rsp_valid();
        repeat (3) @(posedge clk);
        hold_rsp = 0;
        drain();
        for (int i = 0; i < N; i++)
            chk("stat_grants", 64'(stat_grants[i*16 +: 16]),
                64'((m_grants[i] > 65535) ? 65535 : m_grants[i]));
        chk("stat_stall", 64'(stat_stall), 64'((m_stall > 65535) ? 65535 : m_stall));
`endif

        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
